dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/dmem_resp.sv | 195 +++++++++++++++++++
 tb/tb_dmem_resp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - FSM state type and state constants (ST_IDLE / ST_WAIT / ST_RESP)
// Configuration: DMEM_SUBWORD_EN (used by dmem_resp) enables byte/half accesses.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering for little-endian sub-word accesses.
//   i_size   : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_lo     : byte offset within the word (addr[1:0])
//   i_signed : sign-extend sub-word loads when 1
//   i_wdata  : right-aligned store data
//   i_rword  : raw storage word at the addressed location
//   o_rdata  : load data shifted to bit 0 and extended
//   o_wdata  : store data replicated onto every candidate lane
//   o_be     : byte-lane write enables for a store
// Alignment errors are checked by the caller; this block assumes aligned input.
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lo,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be
);

    logic [31:0] w_shift;

    // Bring the addressed lane(s) down to bit 0.
    assign w_shift = i_rword >> {i_lo, 3'b000};

    always_comb begin
        o_rdata = i_rword;
        o_wdata = i_wdata;
        o_be    = 4'hF;
        case (i_size)
            SZ_BYTE: begin
                o_rdata = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
                o_wdata = {4{i_wdata[7:0]}};
                o_be    = 4'b0001 << i_lo;
            end
            SZ_HALF: begin
                o_rdata = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
                o_wdata = {2{i_wdata[15:0]}};
                o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Single-port data memory with a valid/ready request channel and a
// valid/ready response channel, plus a fixed number of wait states.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset (storage is not cleared)
//   req_valid/req_ready : request handshake (ready only when idle)
//   req_we     : 1 store, 0 load
//   req_addr   : byte address
//   req_wdata  : right-aligned store data
//   req_size   : 00 byte, 01 half, 10 word, 11 reserved
//   req_signed : sign-extend sub-word loads
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata  : load data (0 for stores and errors)
//   rsp_err    : access rejected (misaligned, bad size, out of range)
// Parameters: DEPTH_WORDS (power of two), WAIT_CYCLES (0..15).
// Macro DMEM_SUBWORD_EN: when defined, byte/half accesses are supported via
// dmem_lane_align; otherwise only aligned word accesses are legal.
// -----------------------------------------------------------------------------
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_in_idle;
    logic          w_accept;
    logic          w_enter_resp;
    logic          w_acc_we;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic [1:0]    w_acc_size;
    logic          w_acc_signed;
    logic          w_size_err;
    logic          w_range_err;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [31:0]   w_load_data;
    logic [31:0]   w_store_data;
    logic [3:0]    w_be;
    logic          w_mem_we;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_accept  = req_valid & w_in_idle;

    // With zero wait states the access happens on the accept edge itself, so
    // the request fields are taken straight from the inputs while idle.
    assign w_acc_we     = w_in_idle ? req_we     : r_we;
    assign w_acc_addr   = w_in_idle ? req_addr   : r_addr;
    assign w_acc_wdata  = w_in_idle ? req_wdata  : r_wdata;
    assign w_acc_size   = w_in_idle ? req_size   : r_size;
    assign w_acc_signed = w_in_idle ? req_signed : r_signed;

    assign w_enter_resp = (w_accept && NO_WAIT) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd1));

    assign w_range_err = (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err       = w_size_err | w_range_err;
    assign w_idx       = w_acc_addr[AW+1:2];
    assign w_rword     = r_mem[w_idx];

`ifdef DMEM_SUBWORD_EN
    always_comb begin
        w_size_err = 1'b0;
        case (w_acc_size)
            SZ_BYTE: w_size_err = 1'b0;
            SZ_HALF: w_size_err = w_acc_addr[0];
            SZ_WORD: w_size_err = (w_acc_addr[1:0] != 2'b00);
            default: w_size_err = 1'b1;
        endcase
    end

    dmem_lane_align u_lane_align (
        .i_size   (w_acc_size),
        .i_lo     (w_acc_addr[1:0]),
        .i_signed (w_acc_signed),
        .i_wdata  (w_acc_wdata),
        .i_rword  (w_rword),
        .o_rdata  (w_load_data),
        .o_wdata  (w_store_data),
        .o_be     (w_be)
    );
`else
    assign w_size_err   = (w_acc_size != SZ_WORD) || (w_acc_addr[1:0] != 2'b00);
    assign w_load_data  = w_rword;
    assign w_store_data = w_acc_wdata;
    assign w_be         = 4'hF;

    // Sign control has no meaning for word-only accesses.
    logic w_unused_signed;
    assign w_unused_signed = w_acc_signed;
`endif

    // Gating with reset keeps a store from landing while reset is held.
    assign w_mem_we = w_enter_resp & w_acc_we & ~w_err & reset;

    // Storage has no reset so contents survive an aborted access.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_store_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_size   <= SZ_WORD;
            r_signed <= 1'b0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_cnt    <= 4'(WAIT_CYCLES);
                        r_state  <= NO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Response payload is captured once, on entry to RESP.
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_acc_we || w_err) ? 32'd0 : w_load_data;
            end
        end
    end

    assign req_ready = w_in_idle;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
// Directed bench for dmem_resp. Instance 0 uses WAIT_CYCLES=2, instance 1 uses
// WAIT_CYCLES=0; both have DEPTH_WORDS=64. Sub-word expectations follow the
// DMEM_SUBWORD_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

    logic             clk = 1'b0;
    logic [1:0]       rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_signed;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] hold_rdata;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Counts edges from the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input int d, output int n);
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) req_valid[d] = 1'b0;
            if (rsp_valid[d]) break;
            if (n >= 32) begin
                check_eq("rsp_timeout", {31'd0, rsp_valid[d]}, 32'd1);
                break;
            end
        end
    endtask

    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                       output logic [31:0] o_rd, output logic o_er, output int o_lat);
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_size[d]   = size;
        req_signed[d] = sgn;
        rsp_ready[d]  = 1'b0;
        wait_rsp(d, o_lat);
        o_rd = rsp_rdata[d];
        o_er = rsp_err[d];
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        rst_n      = 2'b00;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_size   = '0;
        req_signed = '0;
        rsp_ready  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        check_eq("rst_rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
        @(negedge clk);
        rst_n = 2'b11;
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);

        // Word round trip, WAIT_CYCLES=2
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
        check_eq("st10_lat", lat, 32'd3);
        check_eq("st10_err", {31'd0, er}, 32'd0);
        check_eq("st10_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check_eq("ld10_lat", lat, 32'd3);
        check_eq("ld10_err", {31'd0, er}, 32'd0);
        check_eq("ld10_rdata", rd, 32'hDEADBEEF);

        // Sub-word accesses
        txn(0, 1'b1, 32'h20, 32'h80FF7F01, 2'b10, 1'b0, rd, er, lat);
        txn(0, 1'b0, 32'h23, 32'h0, 2'b00, 1'b1, rd, er, lat);
`ifdef DMEM_SUBWORD_EN
        check_eq("ldb23s_rdata", rd, 32'hFFFFFF80);
        check_eq("ldb23s_err", {31'd0, er}, 32'd0);
`else
        check_eq("ldb23s_rdata", rd, 32'd0);
        check_eq("ldb23s_err", {31'd0, er}, 32'd1);
`endif
        txn(0, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, rd, er, lat);
`ifdef DMEM_SUBWORD_EN
        check_eq("ldh22u_rdata", rd, 32'h000080FF);
        check_eq("ldh22u_err", {31'd0, er}, 32'd0);
`else
        check_eq("ldh22u_rdata", rd, 32'd0);
        check_eq("ldh22u_err", {31'd0, er}, 32'd1);
`endif
        txn(0, 1'b1, 32'h21, 32'h000000AA, 2'b00, 1'b0, rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
`ifdef DMEM_SUBWORD_EN
        check_eq("stb21_word", rd, 32'h80FFAA01);
`else
        check_eq("stb21_word", rd, 32'h80FF7F01);
`endif

        // Error cases
        txn(0, 1'b0, 32'h22, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check_eq("ldw22_err", {31'd0, er}, 32'd1);
        check_eq("ldw22_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, rd, er, lat);
        check_eq("ldh21_err", {31'd0, er}, 32'd1);
        check_eq("ldh21_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h22, 32'hFFFFFFFF, 2'b10, 1'b0, rd, er, lat);
        check_eq("stw22_err", {31'd0, er}, 32'd1);
        txn(0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
`ifdef DMEM_SUBWORD_EN
        check_eq("w20_unchanged", rd, 32'h80FFAA01);
`else
        check_eq("w20_unchanged", rd, 32'h80FF7F01);
`endif
        txn(0, 1'b1, 32'h0, 32'h0000A5A5, 2'b10, 1'b0, rd, er, lat);
        txn(0, 1'b1, 32'h100, 32'h12121212, 2'b10, 1'b0, rd, er, lat);
        check_eq("st100_err", {31'd0, er}, 32'd1);
        txn(0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check_eq("ld100_err", {31'd0, er}, 32'd1);
        check_eq("ld100_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check_eq("w00_unchanged", rd, 32'h0000A5A5);

        // Backpressure: hold rsp_ready low for 5 cycles
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
        req_size[0] = 2'b10; req_signed[0] = 1'b0; rsp_ready[0] = 1'b0;
        wait_rsp(0, lat);
        hold_rdata = rsp_rdata[0];
        check_eq("bp_first_rdata", hold_rdata, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            check_eq("bp_rdata", rsp_rdata[0], hold_rdata);
            check_eq("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0; req_size[0] = 2'b10;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        check_eq("bp_hs_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check_eq("bp_hs_req_ready", {31'd0, req_ready[0]}, 32'd1);
        wait_rsp(0, lat);
        check_eq("bp_next_lat", lat, 32'd3);
        check_eq("bp_next_rdata", rsp_rdata[0], 32'h0000A5A5);
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;

        // Reset in the middle of WAIT
        txn(0, 1'b1, 32'h30, 32'h0BADF00D, 2'b10, 1'b0, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'h12345678; req_size[0] = 2'b10;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check_eq("mw_req_ready", {31'd0, req_ready[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        #1;
        check_eq("mw_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check_eq("mw_rst_rdata", rsp_rdata[0], 32'd0);
        check_eq("mw_rst_err", {31'd0, rsp_err[0]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        #1;
        check_eq("mw_req_ready_after", {31'd0, req_ready[0]}, 32'd1);
        txn(0, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check_eq("mw_w30_prior", rd, 32'h0BADF00D);

        // WAIT_CYCLES=0 instance
        txn(1, 1'b1, 32'h8, 32'h01020304, 2'b10, 1'b0, rd, er, lat);
        check_eq("w0_st_lat", lat, 32'd1);
        txn(1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check_eq("w0_ld_lat", lat, 32'd1);
        check_eq("w0_ld_rdata", rd, 32'h01020304);
        txn(1, 1'b0, 32'h8, 32'h0, 2'b00, 1'b0, rd, er, lat);
`ifdef DMEM_SUBWORD_EN
        check_eq("w0_ldb_err", {31'd0, er}, 32'd0);
        check_eq("w0_ldb_rdata", rd, 32'h00000004);
`else
        check_eq("w0_ldb_err", {31'd0, er}, 32'd1);
        check_eq("w0_ldb_rdata", rd, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
